// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding one UART transmitter, with a done-timeout
// and a small CSR bank (enable, status, timeout, byte count).
module uart_tx_arbiter #(
   parameter logic [3:0]  csr_addr        = 4'h0,
   parameter logic [15:0] timeout_default = 16'hFFFF
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   input  logic        tx_done,
   input  logic [13:0] csr_a,
   input  logic        csr_we,
   input  logic [31:0] csr_di,
   output logic [31:0] csr_do
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_last_grant;
   logic [7:0]  r_tx_data;
   logic [3:0]  r_enable;
   logic [15:0] r_timeout;
   logic [15:0] r_timer;
   logic        r_flag;
   logic [15:0] r_count;
   logic [31:0] r_csr_do;

   logic [3:0]  w_eligible;
   logic        w_grant_vld;
   logic [1:0]  w_grant_idx;
   logic        w_accept;
   logic        w_issue;
   logic        w_done_cnt;
   logic        w_expire;
   logic        w_sel;
   logic [2:0]  w_idx;
   logic        w_wr;
   logic [31:0] w_rd_data;
   logic        w_unused;

   assign w_eligible = req_valid & r_enable;

   // Descending scan so the lowest offset from last_grant+1 is the one that sticks.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         if (w_eligible[r_last_grant + 2'(k)]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = r_last_grant + 2'(k);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      w_done_cnt  = 1'b0;
      w_expire    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_grant_vld) begin
               w_accept    = 1'b1;
               w_state_nxt = StIssue;
            end
         end
         StIssue: begin
            w_issue     = 1'b1;
            w_state_nxt = StWait;
         end
         StWait: begin
            if (tx_done) begin
               w_done_cnt  = 1'b1;
               w_state_nxt = StIdle;
            end else if (r_timer == 16'd1) begin
               w_expire    = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign req_ready = (w_accept && !sys_rst) ? (4'b0001 << w_grant_idx) : 4'b0000;
   assign tx_wr     = w_issue && !sys_rst;
   assign tx_data   = r_tx_data;
   assign csr_do    = r_csr_do;

   assign w_sel    = (csr_a[13:10] == csr_addr);
   assign w_idx    = csr_a[2:0];
   assign w_wr     = w_sel && csr_we;
   assign w_unused = ^{csr_a[9:3], csr_di[31:16]};

   always_comb begin
      w_rd_data = 32'd0;
      if (w_sel) begin
         case (w_idx)
            3'd0:    w_rd_data = {28'd0, r_enable};
            3'd1:    w_rd_data = {28'd0, r_flag, (r_state != StIdle), r_last_grant};
            3'd2:    w_rd_data = {16'd0, r_timeout};
            3'd3:    w_rd_data = {16'd0, r_count};
            default: w_rd_data = 32'd0;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state      <= StIdle;
         r_last_grant <= 2'd3;
         r_tx_data    <= 8'd0;
         r_enable     <= 4'hF;
         r_timeout    <= timeout_default;
         r_timer      <= 16'd0;
         r_flag       <= 1'b0;
         r_count      <= 16'd0;
         r_csr_do     <= 32'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_csr_do <= w_rd_data;
         if (w_accept) begin
            r_last_grant <= w_grant_idx;
            r_tx_data    <= req_data[{w_grant_idx, 3'b000} +: 8];
         end
         // A timeout value written mid-wait only matters from the next load.
         if (w_issue) begin
            r_timer <= r_timeout;
         end else if (r_state == StWait && r_timer != 16'd0) begin
            r_timer <= r_timer - 16'd1;
         end
         if (w_wr && w_idx == 3'd0) begin
            r_enable <= csr_di[3:0];
         end
         if (w_wr && w_idx == 3'd2) begin
            r_timeout <= csr_di[15:0];
         end
         if (w_expire) begin
            r_flag <= 1'b1;
         end else if (w_wr && w_idx == 3'd1 && csr_di[3]) begin
            r_flag <= 1'b0;
         end
         if (w_wr && w_idx == 3'd3) begin
            r_count <= 16'd0;
         end else if (w_done_cnt) begin
            r_count <= r_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model of grants, timeouts and CSR state,
// driven with randomized requests, data and completion delays.
module tb_uart_tx_arbiter;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_done;
   logic [13:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;
   logic [31:0] csr_do;

   int checks   = 0;
   int failures = 0;

   int          m_last;
   logic [3:0]  m_en;
   int          m_to;
   logic [15:0] m_count;
   logic        m_flag;

   uart_tx_arbiter dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_wr     (tx_wr),
      .tx_done   (tx_done),
      .csr_a     (csr_a),
      .csr_we    (csr_we),
      .csr_di    (csr_di),
      .csr_do    (csr_do)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic csr_write(input logic [3:0] bank, input logic [2:0] idx, input logic [31:0] v);
      @(negedge sys_clk);
      csr_a  = {bank, 7'd0, idx};
      csr_we = 1'b1;
      csr_di = v;
      @(negedge sys_clk);
      csr_we = 1'b0;
   endtask

   task automatic csr_read(input logic [3:0] bank, input logic [2:0] idx, output logic [31:0] v);
      @(negedge sys_clk);
      csr_a  = {bank, 7'd0, idx};
      csr_we = 1'b0;
      @(negedge sys_clk);
      #1;
      v = csr_do;
   endtask

   task automatic do_reset();
      sys_rst   = 1'b1;
      req_valid = 4'd0;
      tx_done   = 1'b0;
      csr_we    = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      m_last  = 3;
      m_en    = 4'hF;
      m_to    = 16'hFFFF;
      m_count = 16'd0;
      m_flag  = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic [31:0] exp_rd [6];
      logic [2:0]  idxs [6];
      sys_rst   = 1'b1;
      req_valid = 4'hF;
      req_data  = $urandom;
      tx_done   = 1'b1;
      csr_a     = 14'd0;
      csr_we    = 1'b0;
      csr_di    = 32'd0;
      repeat (2) @(negedge sys_clk);
      #1;
      checks++;
      if (req_ready !== 4'd0) begin
         failures++;
         $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      checks++;
      if (tx_wr !== 1'b0 || tx_data !== 8'd0 || csr_do !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs: tx_wr=%b tx_data=%h csr_do=%h want 0/00/0",
                  tx_wr, tx_data, csr_do);
      end
      @(negedge sys_clk);
      sys_rst   = 1'b0;
      req_valid = 4'd0;
      tx_done   = 1'b0;
      m_last  = 3;
      m_en    = 4'hF;
      m_to    = 16'hFFFF;
      m_count = 16'd0;
      m_flag  = 1'b0;
      idxs   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
      exp_rd = '{32'hF, 32'h3, 32'hFFFF, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 6; i++) begin
         csr_read(4'h0, idxs[i], rd);
         checks++;
         if (rd !== exp_rd[i]) begin
            failures++;
            $display("FAIL reset_csr idx=%0d: got %h want %h", idxs[i], rd, exp_rd[i]);
         end
      end
      csr_read(4'h1, 3'd0, rd);
      checks++;
      if (rd !== 32'd0) begin
         failures++;
         $display("FAIL unselected_bank: got %h want 0", rd);
      end
   endtask

   task automatic test_single();
      logic [31:0] rd;
      do_reset();
      @(negedge sys_clk);
      req_valid = 4'b0001;
      req_data  = {$urandom_range(0, 16'hFFFF), 8'h00, 8'h41};
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_grant: got %b want 0001", req_ready);
      end
      @(negedge sys_clk);
      req_valid = 4'd0;
      csr_a     = {4'h0, 7'd0, 3'd1};
      #1;
      checks++;
      if (tx_wr !== 1'b1 || tx_data !== 8'h41 || req_ready !== 4'd0) begin
         failures++;
         $display("FAIL single_issue: tx_wr=%b tx_data=%h ready=%b want 1/41/0000",
                  tx_wr, tx_data, req_ready);
      end
      @(negedge sys_clk);
      #1;
      checks++;
      if (tx_wr !== 1'b0 || csr_do[2] !== 1'b1) begin
         failures++;
         $display("FAIL single_wait: tx_wr=%b busy=%b want 0/1", tx_wr, csr_do[2]);
      end
      @(negedge sys_clk);
      tx_done = 1'b1;
      @(negedge sys_clk);
      tx_done = 1'b0;
      m_count = 16'd1;
      m_last  = 0;
      csr_read(4'h0, 3'd3, rd);
      checks++;
      if (rd !== 32'd1) begin
         failures++;
         $display("FAIL single_count: got %h want 1", rd);
      end
   endtask

   // fv = 0 picks random request vectors; completion arrives d WAIT cycles after issue.
   task automatic test_traffic(input string name, input int n, input logic [3:0] fv,
                               input int dmin, input int dmax, input logic cw_en,
                               input logic [2:0] cw_idx, input logic [31:0] cw_val);
      logic [3:0]  v;
      logic [3:0]  elig;
      logic [3:0]  exp_rdy;
      logic [7:0]  exp_byte;
      logic [31:0] rd;
      int          g;
      int          d;
      int          nwait;
      bit          done_wins;
      for (int t = 0; t < n; t++) begin
         v    = (fv != 4'd0) ? fv : 4'($urandom_range(1, 15));
         elig = v & m_en;
         g    = -1;
         for (int k = 4; k >= 1; k--) begin
            if (elig[(m_last + k) % 4]) g = (m_last + k) % 4;
         end
         exp_rdy = (g < 0) ? 4'd0 : 4'(1 << g);
         @(negedge sys_clk);
         req_valid = v;
         req_data  = $urandom;
         tx_done   = 1'($urandom_range(0, 1));
         csr_we    = 1'b0;
         #1;
         checks++;
         if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL %s_grant t=%0d: got %b want %b", name, t, req_ready, exp_rdy);
         end
         if (g < 0) continue;
         exp_byte = req_data[8*g +: 8];
         m_last   = g;
         @(negedge sys_clk);
         tx_done = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (tx_wr !== 1'b1 || tx_data !== exp_byte || req_ready !== 4'd0) begin
            failures++;
            $display("FAIL %s_issue t=%0d: tx_wr=%b tx_data=%h ready=%b want 1/%h/0000",
                     name, t, tx_wr, tx_data, req_ready, exp_byte);
         end
         d         = $urandom_range(dmin, dmax);
         done_wins = (m_to == 0) || (d <= m_to);
         nwait     = done_wins ? d : m_to;
         for (int w = 1; w <= nwait; w++) begin
            @(negedge sys_clk);
            tx_done = (w == d);
            if (cw_en && w == nwait) begin
               csr_a  = {4'h0, 7'd0, cw_idx};
               csr_di = cw_val;
               csr_we = 1'b1;
            end
            #1;
            checks++;
            if (tx_wr !== 1'b0 || req_ready !== 4'd0 || tx_data !== exp_byte) begin
               failures++;
               $display("FAIL %s_wait t=%0d w=%0d: tx_wr=%b ready=%b tx_data=%h want 0/0000/%h",
                        name, t, w, tx_wr, req_ready, tx_data, exp_byte);
            end
         end
         if (done_wins) m_count = m_count + 16'd1;
         else           m_flag  = 1'b1;
         if (cw_en && cw_idx == 3'd3) m_count = 16'd0;
         if (cw_en && cw_idx == 3'd1 && cw_val[3] && done_wins) m_flag = 1'b0;
         if (cw_en && cw_idx == 3'd0) m_en = cw_val[3:0];
      end
      @(negedge sys_clk);
      req_valid = 4'd0;
      tx_done   = 1'b0;
      csr_we    = 1'b0;
      csr_read(4'h0, 3'd3, rd);
      checks++;
      if (rd !== {16'd0, m_count}) begin
         failures++;
         $display("FAIL %s_count: got %h want %h", name, rd, m_count);
      end
      csr_read(4'h0, 3'd1, rd);
      checks++;
      if (rd !== {28'd0, m_flag, 1'b0, 2'(m_last)}) begin
         failures++;
         $display("FAIL %s_status: got %h want %h", name, rd, {28'd0, m_flag, 1'b0, 2'(m_last)});
      end
   endtask

   task automatic test_enable_mask();
      csr_write(4'h0, 3'd0, 32'h5);
      m_en = 4'h5;
      test_traffic("enable_mask", 6, 4'hF, 1, 4, 1'b0, 3'd0, 32'd0);
      // Dropping requester 2's enable during its own transfer must let it finish.
      test_traffic("disable_in_flight", 1, 4'b0100, 3, 3, 1'b1, 3'd0, 32'h1);
      test_traffic("after_disable", 3, 4'hF, 1, 3, 1'b0, 3'd0, 32'd0);
   endtask

   task automatic test_timeout();
      logic [31:0] rd;
      csr_write(4'h0, 3'd2, 32'd10);
      m_to = 10;
      test_traffic("timeout", 2, 4'b0001, 20, 20, 1'b0, 3'd0, 32'd0);
      csr_write(4'h0, 3'd1, 32'h8);
      m_flag = 1'b0;
      csr_read(4'h0, 3'd1, rd);
      checks++;
      if (rd[3] !== 1'b0) begin
         failures++;
         $display("FAIL timeout_flag_clear: got %b want 0", rd[3]);
      end
   endtask

   task automatic test_coincident();
      test_traffic("expiry_vs_clear", 1, 4'b0001, 12, 12, 1'b1, 3'd1, 32'h8);
      csr_write(4'h0, 3'd1, 32'h8);
      m_flag = 1'b0;
      test_traffic("done_at_expiry", 1, 4'b0001, 10, 10, 1'b1, 3'd3, 32'h0);
   endtask

   task automatic test_random();
      logic [3:0] en;
      int         to;
      for (int r = 0; r < 3; r++) begin
         en = 4'($urandom_range(1, 15));
         to = $urandom_range(0, 6);
         csr_write(4'h0, 3'd0, {28'd0, en});
         csr_write(4'h0, 3'd2, 32'(to));
         m_en = en;
         m_to = to;
         test_traffic("random", 25, 4'd0, 1, 8, 1'b0, 3'd0, 32'd0);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic [31:0] exp_rd [4];
      do_reset();
      csr_write(4'h0, 3'd0, 32'h6);
      @(negedge sys_clk);
      req_valid = 4'b0100;
      req_data  = {8'h00, 8'hA5, 16'h0000};
      csr_a     = {4'h0, 7'd0, 3'd2};
      @(negedge sys_clk);
      req_valid = 4'hF;
      repeat (2) @(negedge sys_clk);
      #2;
      sys_rst = 1'b1;
      #1;
      checks++;
      if (tx_wr !== 1'b0 || req_ready !== 4'd0 || tx_data !== 8'd0 || csr_do !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid_outputs: tx_wr=%b ready=%b tx_data=%h csr_do=%h want all 0",
                  tx_wr, req_ready, tx_data, csr_do);
      end
      @(negedge sys_clk);
      sys_rst   = 1'b0;
      req_valid = 4'd0;
      tx_done   = 1'b1;
      @(negedge sys_clk);
      tx_done = 1'b0;
      exp_rd = '{32'hF, 32'h3, 32'hFFFF, 32'h0};
      for (int i = 0; i < 4; i++) begin
         csr_read(4'h0, 3'(i), rd);
         checks++;
         if (rd !== exp_rd[i]) begin
            failures++;
            $display("FAIL reset_mid_csr idx=%0d: got %h want %h", i, rd, exp_rd[i]);
         end
      end
   endtask

   initial begin
      req_valid = 4'd0;
      req_data  = 32'd0;
      tx_done   = 1'b0;
      csr_a     = 14'd0;
      csr_we    = 1'b0;
      csr_di    = 32'd0;
      sys_rst   = 1'b1;
      test_reset();
      test_single();
      do_reset();
      test_traffic("round_robin", 5, 4'hF, 5, 5, 1'b0, 3'd0, 32'd0);
      test_enable_mask();
      test_timeout();
      test_coincident();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
